// File: rtl/tree_acc_if.sv
// ============================================================================
// Module   : tree_acc_if
// Brief    : Input-beat and result handshake bundle for tree_acc_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tree_acc_if #(
    parameter int K         = 16,
    parameter int WIDTH     = 13,
    parameter int ACC_WIDTH = 24
);
    logic                   in_valid;
    logic                   in_ready;
    logic [K*WIDTH-1:0]     in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_WIDTH-1:0]   out_sum;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

`default_nettype wire

// File: rtl/tree_acc_ctrl.sv
// ============================================================================
// Module   : tree_acc_ctrl
// Brief    : Multi-beat signed reduction: K elements per beat summed into an
//            accumulator over cfg_beats beats. Define TREE_ACC_SAT_EN for a
//            saturating accumulator; default build wraps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tree_acc_ctrl #(
    parameter int K         = 16,
    parameter int WIDTH     = 13,
    parameter int ACC_WIDTH = 24,
    parameter int LEN_W     = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [LEN_W-1:0]  cfg_beats,
    tree_acc_if.slave              bus,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [LEN_W-1:0]       r_n;
    logic [LEN_W-1:0]       r_cnt;
    logic [ACC_WIDTH-1:0]   r_psum;
    logic                   r_stage_v;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [ACC_WIDTH-1:0]   r_out_sum;
    logic                   r_busy;

    logic                   w_accept;
    logic [LEN_W-1:0]       w_n_cfg;
    logic [ACC_WIDTH-1:0]   w_psum;
    logic [ACC_WIDTH-1:0]   w_acc_next;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_n_cfg  = (cfg_beats == '0) ? LEN_W'(1) : cfg_beats;

    // ACC_WIDTH >= WIDTH+clog2(K) guarantees this per-beat sum cannot overflow.
    always_comb begin
        w_psum = '0;
        for (int i = 0; i < K; i++) begin
            w_psum = w_psum + {{(ACC_WIDTH-WIDTH){bus.in_data[i*WIDTH+WIDTH-1]}},
                               bus.in_data[i*WIDTH +: WIDTH]};
        end
    end

`ifdef TREE_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic [ACC_WIDTH:0] w_sum_ext;

    // One guard bit: top two bits differing means the signed add overflowed.
    always_comb begin
        w_sum_ext = {r_acc[ACC_WIDTH-1], r_acc} + {r_psum[ACC_WIDTH-1], r_psum};
        if (w_sum_ext[ACC_WIDTH] != w_sum_ext[ACC_WIDTH-1])
            w_acc_next = w_sum_ext[ACC_WIDTH] ? c_acc_min : c_acc_max;
        else
            w_acc_next = w_sum_ext[ACC_WIDTH-1:0];
    end
`else
    assign w_acc_next = r_acc + r_psum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_cnt       <= '0;
            r_psum      <= '0;
            r_stage_v   <= 1'b0;
            r_acc       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_stage_v <= w_accept;
            if (w_accept)
                r_psum <= w_psum;

            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_n    <= w_n_cfg;
                        r_cnt  <= LEN_W'(1);
                        r_acc  <= '0;
                        r_busy <= 1'b1;
                        if (w_n_cfg == LEN_W'(1)) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (r_stage_v)
                        r_acc <= w_acc_next;
                    if (w_accept) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (r_cnt == r_n - LEN_W'(1)) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                // Only the final beat's partial sum can be pending here.
                S_DRAIN: begin
                    if (r_stage_v) begin
                        r_acc       <= w_acc_next;
                        r_out_sum   <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_acc       <= '0;
                        r_stage_v   <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_sum   <= '0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_tree_acc_ctrl.sv
// ============================================================================
// Module   : tb_tree_acc_ctrl
// Brief    : Directed bench for tree_acc_ctrl (K=4, WIDTH=8; ACC_WIDTH 20 and 12).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tree_acc_ctrl;
    localparam int K       = 4;
    localparam int WIDTH   = 8;
    localparam int ACC_W   = 20;
    localparam int ACC_W12 = 12;
    localparam int LEN_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [LEN_W-1:0] cfg_beats;
    logic [LEN_W-1:0] cfg_beats12;
    logic             busy;
    logic             busy12;

    int n_checks   = 0;
    int n_fail     = 0;
    int n_accepted = 0;

    tree_acc_if #(.K(K), .WIDTH(WIDTH), .ACC_WIDTH(ACC_W))   bus ();
    tree_acc_if #(.K(K), .WIDTH(WIDTH), .ACC_WIDTH(ACC_W12)) bus12 ();

    tree_acc_ctrl #(.K(K), .WIDTH(WIDTH), .ACC_WIDTH(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .cfg_beats(cfg_beats), .bus(bus.slave), .busy(busy)
    );

    tree_acc_ctrl #(.K(K), .WIDTH(WIDTH), .ACC_WIDTH(ACC_W12), .LEN_W(LEN_W)) dut12 (
        .clk(clk), .rst(rst), .cfg_beats(cfg_beats12), .bus(bus12.slave), .busy(busy12)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.in_valid && bus.in_ready) n_accepted <= n_accepted + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [K*WIDTH-1:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Presents one beat, waits (bounded) for in_ready, returns one cycle after acceptance.
    task automatic send_beat(input logic [K*WIDTH-1:0] data);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_beat_timeout: in_ready=%b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_sum !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_sum=%0d busy=%b required 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_sum, busy);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus12.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b busy=%b in_ready12=%b required 1 0 1",
                     bus.in_ready, busy, bus12.in_ready);
        end
    endtask

    task automatic test_single_beat();
        cfg_beats = 8'd1;
        send_beat(pack4(1, 2, 3, 4));
        n_checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_t1: out_valid=%b busy=%b in_ready=%b required 0 1 0",
                     bus.out_valid, busy, bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 20'd10) begin
            n_fail++;
            $display("FAIL single_t2: out_valid=%b out_sum=%0d required 1 10",
                     bus.out_valid, $signed(bus.out_sum));
        end
        handshake();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== '0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_release: out_valid=%b out_sum=%0d busy=%b in_ready=%b required 0 0 0 1",
                     bus.out_valid, bus.out_sum, busy, bus.in_ready);
        end
    endtask

    task automatic test_gaps();
        int start;
        logic [ACC_W-1:0] exp_sum;
        logic gap_bad;
        exp_sum   = -20'sd1536;
        gap_bad   = 1'b0;
        start     = n_accepted;
        cfg_beats = 8'd3;
        for (int b = 0; b < 3; b++) begin
            send_beat(pack4(-128, -128, -128, -128));
            if (b < 2) begin
                tick();
                if (busy !== 1'b1 || bus.out_valid !== 1'b0) gap_bad = 1'b1;
                tick();
                if (busy !== 1'b1 || bus.out_valid !== 1'b0) gap_bad = 1'b1;
            end
        end
        n_checks++;
        if (gap_bad) begin
            n_fail++;
            $display("FAIL gaps_stall: busy/out_valid wrong during in_valid gap, required busy=1 out_valid=0");
        end
        // Extra data offered while draining/holding must not be taken.
        bus.in_valid = 1'b1;
        bus.in_data  = pack4(7, 7, 7, 7);
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_sum) begin
            n_fail++;
            $display("FAIL gaps_sum: out_valid=%b out_sum=%0d required 1 -1536",
                     bus.out_valid, $signed(bus.out_sum));
        end
        tick();
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (n_accepted - start !== 3) begin
            n_fail++;
            $display("FAIL gaps_count: accepted=%0d required 3", n_accepted - start);
        end
        handshake();
    endtask

    task automatic test_hold_stall();
        logic stall_bad;
        stall_bad = 1'b0;
        cfg_beats = 8'd2;
        send_beat(pack4(10, 20, 30, 40));
        send_beat(pack4(-1, -1, -1, -1));
        tick();
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 20'd96 || bus.in_ready !== 1'b0)
                stall_bad = 1'b1;
            tick();
        end
        n_checks++;
        if (stall_bad || bus.out_valid !== 1'b1 || bus.out_sum !== 20'd96) begin
            n_fail++;
            $display("FAIL hold_stall: out_valid=%b out_sum=%0d in_ready=%b required 1 96 0 throughout",
                     bus.out_valid, $signed(bus.out_sum), bus.in_ready);
        end
        handshake();
        n_checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: busy=%b out_valid=%b in_ready=%b required 0 0 1",
                     busy, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_zero_beats();
        cfg_beats = 8'd0;
        send_beat(pack4(5, 5, 5, 5));
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_t1: out_valid=%b in_ready=%b required 0 0", bus.out_valid, bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 20'd20) begin
            n_fail++;
            $display("FAIL zero_sum: out_valid=%b out_sum=%0d required 1 20",
                     bus.out_valid, $signed(bus.out_sum));
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        logic spurious;
        spurious  = 1'b0;
        cfg_beats = 8'd4;
        send_beat(pack4(9, 9, 9, 9));
        send_beat(pack4(9, 9, 9, 9));
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: busy=%b in_ready=%b out_valid=%b required 0 0 0",
                     busy, bus.in_ready, bus.out_valid);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        n_checks++;
        if (spurious) begin
            n_fail++;
            $display("FAIL rst_mid_spurious: out_valid or busy asserted after reset, required 0");
        end
        cfg_beats = 8'd1;
        send_beat(pack4(1, 1, 1, 1));
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 20'd4) begin
            n_fail++;
            $display("FAIL rst_mid_after: out_valid=%b out_sum=%0d required 1 4",
                     bus.out_valid, $signed(bus.out_sum));
        end
        handshake();
    endtask

    // Five back-to-back beats of 4*127 overflow a 12-bit accumulator.
    task automatic test_overflow();
        logic [ACC_W12-1:0] exp12;
        logic ready_bad;
`ifdef TREE_ACC_SAT_EN
        exp12 = 12'sd2047;
`else
        exp12 = -12'sd1556;
`endif
        ready_bad       = 1'b0;
        cfg_beats12     = 8'd5;
        bus12.in_valid  = 1'b1;
        bus12.in_data   = pack4(127, 127, 127, 127);
        for (int i = 0; i < 5; i++) begin
            if (bus12.in_ready !== 1'b1) ready_bad = 1'b1;
            tick();
        end
        bus12.in_valid = 1'b0;
        n_checks++;
        if (ready_bad || bus12.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_b2b_ready: in_ready not 1 for each of 5 beats then 0 (now %b)", bus12.in_ready);
        end
        tick();
        n_checks++;
        if (bus12.out_valid !== 1'b1 || bus12.out_sum !== exp12) begin
            n_fail++;
            $display("FAIL ovf_sum: out_valid=%b out_sum=%0d required 1 %0d",
                     bus12.out_valid, $signed(bus12.out_sum), $signed(exp12));
        end
        bus12.out_ready = 1'b1;
        tick();
        bus12.out_ready = 1'b0;
        n_checks++;
        if (busy12 !== 1'b0 || bus12.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_release: busy=%b out_valid=%b required 0 0", busy12, bus12.out_valid);
        end
    endtask

    initial begin
        rst             = 1'b1;
        cfg_beats       = '0;
        cfg_beats12     = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        bus12.in_valid  = 1'b0;
        bus12.in_data   = '0;
        bus12.out_ready = 1'b0;

        test_reset();
        test_single_beat();
        test_gaps();
        test_hold_stall();
        test_zero_beats();
        test_reset_mid();
        test_overflow();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
